// File: rtl/spi_slave_m.sv
// SPI mode-0 peripheral: oversamples SCK/CS/MOSI on CLK, shifts MSB first, one-entry TX holding register.
// RX word is reported SYNC_STAGES+1 CLK after the final SCK rise is captured; RX has no backpressure.
module spi_slave_m #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             UNDERRUN,
    output logic             BUSY
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   word_done_q, word_done_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic tx_wr, load_c;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign tx_wr    = TX_VALID & ~hold_full_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        count_d     = count_q;
        word_done_d = word_done_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load_c      = 1'b0;

        // A full count is reported one cycle after the last bit lands, even if CS rises now.
        if (count_q == CNT_FULL) begin
            rx_data_d   = rx_shift_q;
            rx_valid_d  = 1'b1;
            count_d     = '0;
            word_done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    count_d     = '0;
                    word_done_d = 1'b0;
                    load_c      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    count_d     = '0;
                    word_done_d = 1'b0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    count_d    = count_q + CW'(1);
                end else if (sck_fall) begin
                    if (count_q == '0 && word_done_q) begin
                        load_c      = 1'b1;
                        word_done_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load consumes the old holding content before a same-cycle write refills it.
        if (load_c) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d  = '0;
                underrun_d  = 1'b1;
            end
        end
        if (tx_wr) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            count_q     <= '0;
            word_done_q <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            count_q     <= count_d;
            word_done_q <= word_done_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign MISO     = tx_shift_q[WIDTH-1] & (state_q == ACTIVE);
    assign MISO_OE  = (state_q == ACTIVE);
    assign TX_READY = ~hold_full_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign UNDERRUN = underrun_q;
    assign BUSY     = ~cs_s;

endmodule

// File: tb/tb_spi_slave_m.sv
// Bench for spi_slave_m: acts as mode-0 SPI master, scoreboards received words.
module tb_spi_slave_m;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SCK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic [7:0] RX_DATA;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int udr_cnt = 0;
    logic [7:0] rx_exp_q[$];

    spi_slave_m #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .UNDERRUN(UNDERRUN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every reported word must match the oldest word the master sent.
    always @(negedge CLK) begin
        if (!RST && RX_VALID) begin
            rxv_cnt++;
            checks++;
            if (rx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %02h, no word expected", RX_DATA);
            end else begin
                logic [7:0] e;
                e = rx_exp_q.pop_front();
                if (RX_DATA !== e) begin
                    errors++;
                    $display("FAIL rx_data: got %02h expected %02h", RX_DATA, e);
                end
            end
        end
        if (!RST && UNDERRUN) udr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int t;
        t = 0;
        while (!TX_READY && t < 400) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (!TX_READY) begin
            errors++;
            $display("FAIL tx_ready_timeout: TX_READY=%0b after %0d cycles, expected 1", TX_READY, t);
        end else begin
            TX_DATA  = d;
            TX_VALID = 1'b1;
            @(negedge CLK);
            TX_VALID = 1'b0;
        end
    endtask

    // Drives n bits of b MSB first; samples MISO just before each SCK rise.
    task automatic xfer_bits(input logic [7:0] b, input int n, input int hp, output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = b[i];
            repeat (hp) @(negedge CLK);
            m[i] = MISO;
            SCK = 1'b1;
            repeat (hp) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    task automatic cs_end(input int hp);
        repeat (hp) @(negedge CLK);
        CS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        wait_clk(4);
        checks++;
        if ({MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags: MISO/OE/RDY/RXV/UDR/BUSY=%06b expected 001000",
                     {MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY});
        end
        checks++;
        if (RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %02h expected 00", RX_DATA);
        end
        RST = 1'b0;
        wait_clk(4);
        checks++;
        if (BUSY !== 1'b0 || MISO_OE !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: BUSY=%0b MISO_OE=%0b expected 0 0", BUSY, MISO_OE);
        end
    endtask

    task automatic test_basic;
        logic [7:0] m;
        int r0, u0;
        r0 = rxv_cnt; u0 = udr_cnt;
        tx_write(8'hA5);
        CS = 1'b0;
        wait_clk(6);
        checks++;
        if (BUSY !== 1'b1 || MISO_OE !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_oe: BUSY=%0b MISO_OE=%0b expected 1 1", BUSY, MISO_OE);
        end
        rx_exp_q.push_back(8'h3C);
        xfer_bits(8'h3C, 8, 8, m);
        cs_end(8);
        checks++;
        if (m !== 8'hA5) begin
            errors++;
            $display("FAIL basic_miso: got %02h expected a5", m);
        end
        checks++;
        if (RX_DATA !== 8'h3C || rxv_cnt - r0 != 1) begin
            errors++;
            $display("FAIL basic_rx: RX_DATA=%02h pulses=%0d expected 3c 1", RX_DATA, rxv_cnt - r0);
        end
        // Trailing SCK fall loads a next word from an empty register.
        checks++;
        if (udr_cnt - u0 != 1) begin
            errors++;
            $display("FAIL basic_underrun: pulses=%0d expected 1", udr_cnt - u0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] m1, m2;
        int r0, u0;
        r0 = rxv_cnt; u0 = udr_cnt;
        tx_write(8'h11);
        CS = 1'b0;
        wait_clk(6);
        checks++;
        if (TX_READY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_load1: TX_READY=%0b expected 1", TX_READY);
        end
        tx_write(8'h22);
        checks++;
        if (TX_READY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_full: TX_READY=%0b expected 0", TX_READY);
        end
        rx_exp_q.push_back(8'hC3);
        xfer_bits(8'hC3, 8, 8, m1);
        wait_clk(5);
        checks++;
        if (TX_READY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_load2: TX_READY=%0b expected 1", TX_READY);
        end
        rx_exp_q.push_back(8'h96);
        xfer_bits(8'h96, 8, 8, m2);
        cs_end(8);
        checks++;
        if (m1 !== 8'h11 || m2 !== 8'h22) begin
            errors++;
            $display("FAIL b2b_miso: got %02h %02h expected 11 22", m1, m2);
        end
        checks++;
        if (rxv_cnt - r0 != 2 || udr_cnt - u0 != 1) begin
            errors++;
            $display("FAIL b2b_counts: rx_pulses=%0d underruns=%0d expected 2 1", rxv_cnt - r0, udr_cnt - u0);
        end
    endtask

    task automatic test_underrun;
        logic [7:0] m;
        int r0, u0;
        r0 = rxv_cnt; u0 = udr_cnt;
        CS = 1'b0;
        rx_exp_q.push_back(8'hFF);
        xfer_bits(8'hFF, 8, 8, m);
        checks++;
        if (udr_cnt - u0 != 1) begin
            errors++;
            $display("FAIL underrun_start: pulses=%0d expected 1", udr_cnt - u0);
        end
        cs_end(8);
        checks++;
        if (m !== 8'h00) begin
            errors++;
            $display("FAIL underrun_miso: got %02h expected 00", m);
        end
        checks++;
        if (RX_DATA !== 8'hFF || rxv_cnt - r0 != 1 || udr_cnt - u0 != 2) begin
            errors++;
            $display("FAIL underrun_rx: RX_DATA=%02h rx_pulses=%0d underruns=%0d expected ff 1 2",
                     RX_DATA, rxv_cnt - r0, udr_cnt - u0);
        end
    endtask

    task automatic test_abort;
        logic [7:0] m;
        int r0;
        r0 = rxv_cnt;
        CS = 1'b0;
        xfer_bits(8'hE7, 5, 8, m);
        cs_end(8);
        checks++;
        if (rxv_cnt - r0 != 0 || RX_DATA !== 8'hFF) begin
            errors++;
            $display("FAIL abort_no_rx: rx_pulses=%0d RX_DATA=%02h expected 0 ff", rxv_cnt - r0, RX_DATA);
        end
        CS = 1'b0;
        rx_exp_q.push_back(8'h81);
        xfer_bits(8'h81, 8, 8, m);
        cs_end(8);
        checks++;
        if (RX_DATA !== 8'h81 || rxv_cnt - r0 != 1) begin
            errors++;
            $display("FAIL abort_recover: RX_DATA=%02h rx_pulses=%0d expected 81 1", RX_DATA, rxv_cnt - r0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] m;
        tx_write(8'h77);
        CS = 1'b0;
        wait_clk(6);
        tx_write(8'h66);
        xfer_bits(8'hF0, 3, 8, m);
        checks++;
        if (TX_READY !== 1'b0 || MISO_OE !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: TX_READY=%0b MISO_OE=%0b expected 0 1", TX_READY, MISO_OE);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY} !== 6'b001000) begin
            errors++;
            $display("FAIL rst_mid_flags: MISO/OE/RDY/RXV/UDR/BUSY=%06b expected 001000",
                     {MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY});
        end
        checks++;
        if (RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_rx_data: got %02h expected 00", RX_DATA);
        end
        CS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(4);
        RST = 1'b0;
        wait_clk(6);
        checks++;
        if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: TX_READY=%0b BUSY=%0b expected 1 0", TX_READY, BUSY);
        end
    endtask

    task automatic test_stream_fast;
        logic [7:0] m, b;
        int r0, u0;
        r0 = rxv_cnt; u0 = udr_cnt;
        tx_write(8'($urandom));
        CS = 1'b0;
        for (int w = 0; w < 100; w++) begin
            b = 8'($urandom);
            rx_exp_q.push_back(b);
            fork
                tx_write(8'($urandom));
                xfer_bits(b, 8, 2, m);
            join
        end
        cs_end(2);
        checks++;
        if (rxv_cnt - r0 != 100) begin
            errors++;
            $display("FAIL stream_rx_count: got %0d expected 100", rxv_cnt - r0);
        end
        checks++;
        if (udr_cnt - u0 != 0) begin
            errors++;
            $display("FAIL stream_underrun: got %0d expected 0", udr_cnt - u0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_stream_fast();
        checks++;
        if (rx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words never received, expected 0", rx_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
